// File: rtl/lane_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lane_adder_pkg: lane op type and per-lane add/sub helper (SATURATE_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
package lane_adder_pkg;

  // Lanes are computed at this fixed width and trimmed by the caller; DWIDTH <= 64.
  localparam int unsigned LANE_W_MAX = 64;
  localparam int unsigned LANE_IDX_W = 7;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Returns {flag, result}; width is the live lane width, upper bits of a/b are zero.
  function automatic logic [LANE_W_MAX:0] lane_op(
    input logic [LANE_W_MAX-1:0] a,
    input logic [LANE_W_MAX-1:0] b,
    input op_e                   op,
    input logic [LANE_IDX_W-1:0] width
  );
    logic [LANE_W_MAX:0] raw;
    logic [LANE_W_MAX:0] one;
    logic [LANE_W_MAX:0] mask;
    logic [LANE_W_MAX:0] res;
    logic                flag;
    one  = {{LANE_W_MAX{1'b0}}, 1'b1};
    raw  = (op == OP_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    mask = (one << width) - one;
    flag = raw[width];
`ifdef SATURATE_EN
    if (flag) begin
      res = (op == OP_SUB) ? '0 : mask;
    end else begin
      res = raw & mask;
    end
`else
    res = raw & mask;
`endif
    return {flag, res[LANE_W_MAX-1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_lane_adder_pipe_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage: one valid/ready register slice carrying data and flag
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_stage #(
  parameter int DATA_W = 128,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [FLAG_W-1:0] in_flag,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [FLAG_W-1:0] out_flag,
  input  logic              out_ready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [FLAG_W-1:0] flag_q, flag_d;

  assign in_ready = !valid_q || out_ready;

  // Payload only moves on a real transfer so a stalled slice stays frozen.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    flag_d  = flag_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
        flag_d = in_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flag_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_flag  = flag_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_lane_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_lane_adder: LANES-wide add/sub, PIPE_STAGES valid/ready slices (SATURATE_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
module pipelined_lane_adder
  import lane_adder_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DWIDTH-1:0] din0,
  input  logic [LANES*DWIDTH-1:0] din1,
  input  logic                    din_op,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [LANES*DWIDTH-1:0] dout,
  output logic [LANES-1:0]        dout_flag,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [CNT_WIDTH-1:0]    txn_cnt
);

  localparam int BUS_W = LANES * DWIDTH;

  logic [BUS_W-1:0]      lane_res;
  logic [LANES-1:0]      lane_flag;
  logic [LANE_W_MAX:0]   op_res;
  logic                  unused_op_bits;

  always_comb begin
    lane_res       = '0;
    lane_flag      = '0;
    op_res         = '0;
    unused_op_bits = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      op_res = lane_op(LANE_W_MAX'(din0[i*DWIDTH +: DWIDTH]),
                       LANE_W_MAX'(din1[i*DWIDTH +: DWIDTH]),
                       op_e'(din_op),
                       LANE_IDX_W'(DWIDTH));
      lane_res[i*DWIDTH +: DWIDTH] = op_res[DWIDTH-1:0];
      lane_flag[i]                 = op_res[LANE_W_MAX];
      unused_op_bits               = unused_op_bits ^ (^op_res);
    end
  end

  // Index 0 is the arithmetic front end, index k+1 is the output of slice k.
  logic [PIPE_STAGES:0] stg_valid;
  logic [PIPE_STAGES:0] stg_ready;
  logic [BUS_W-1:0]     stg_data [PIPE_STAGES+1];
  logic [LANES-1:0]     stg_flag [PIPE_STAGES+1];

  assign stg_valid[0]           = din_valid;
  assign stg_data[0]            = lane_res;
  assign stg_flag[0]            = lane_flag;
  assign stg_ready[PIPE_STAGES] = dout_ready;
  assign din_ready              = stg_ready[0];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    pipe_stage #(
      .DATA_W (BUS_W),
      .FLAG_W (LANES)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (stg_valid[k]),
      .in_data   (stg_data[k]),
      .in_flag   (stg_flag[k]),
      .in_ready  (stg_ready[k]),
      .out_valid (stg_valid[k+1]),
      .out_data  (stg_data[k+1]),
      .out_flag  (stg_flag[k+1]),
      .out_ready (stg_ready[k+1])
    );
  end

  assign dout       = stg_data[PIPE_STAGES];
  assign dout_flag  = stg_flag[PIPE_STAGES];
  assign dout_valid = stg_valid[PIPE_STAGES];

  logic [CNT_WIDTH-1:0] txn_cnt_q, txn_cnt_d;

  always_comb begin
    txn_cnt_d = txn_cnt_q;
    if (dout_valid && dout_ready) begin
      txn_cnt_d = txn_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt_q <= '0;
    end else begin
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign txn_cnt = txn_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_lane_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipelined_lane_adder: directed + random checks against a lane arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipelined_lane_adder;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int BW = DW * LN;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] din0, din1;
  logic          din_op, din_valid, dout_ready;
  logic          din_ready, dout_valid;
  logic [BW-1:0] dout;
  logic [LN-1:0] dout_flag;
  logic [31:0]   txn_cnt;

  logic          unused_d4_ready, unused_d4_valid;
  logic [BW-1:0] unused_d4_dout;
  logic [LN-1:0] unused_d4_flag;
  logic [3:0]    d4_cnt;

  always #5 clk = ~clk;

  pipelined_lane_adder #(
    .DWIDTH(DW), .LANES(LN), .PIPE_STAGES(2), .CNT_WIDTH(32)
  ) u_dut (
    .clk(clk), .rst(rst), .din0(din0), .din1(din1), .din_op(din_op),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
    .dout_flag(dout_flag), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .txn_cnt(txn_cnt)
  );

  // Same stimulus, narrow counter to exercise wrap-around.
  pipelined_lane_adder #(
    .DWIDTH(DW), .LANES(LN), .PIPE_STAGES(2), .CNT_WIDTH(4)
  ) u_dut4 (
    .clk(clk), .rst(rst), .din0(din0), .din1(din1), .din_op(din_op),
    .din_valid(din_valid), .din_ready(unused_d4_ready), .dout(unused_d4_dout),
    .dout_flag(unused_d4_flag), .dout_valid(unused_d4_valid), .dout_ready(dout_ready),
    .txn_cnt(d4_cnt)
  );

  typedef struct {
    logic [BW-1:0] data;
    logic [LN-1:0] flag;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_pushed = 0;

  function automatic beat_t model(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic op);
    beat_t r;
    for (int l = 0; l < LN; l++) begin
      longint unsigned x, y, d;
      bit f;
      x = longint'(a[l*DW +: DW]);
      y = longint'(b[l*DW +: DW]);
      if (!op) begin
        d = x + y;
        f = (d >= 64'h1_0000_0000);
      end else begin
        f = (x < y);
        d = x - y;
      end
`ifdef SATURATE_EN
      if (f) d = op ? 64'd0 : 64'hFFFF_FFFF;
`endif
      r.data[l*DW +: DW] = d[31:0];
      r.flag[l]          = f;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes mid-cycle, then step to just after the next edge.
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    if (din_valid && din_ready) begin
      exp_q.push_back(model(din0, din1, din_op));
      n_pushed++;
    end
    if (dout_valid && dout_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL stale_beat: observed output %0h expected no beat", dout);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_data", dout, e.data);
        check("sb_flag", BW'(dout_flag), BW'(e.flag));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    din_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n_pushed = 0;
  endtask

  task automatic rand_data();
    din0   = {$urandom, $urandom, $urandom, $urandom};
    din1   = {$urandom, $urandom, $urandom, $urandom};
    din_op = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    check("drain_empty", BW'(exp_q.size()), BW'(0));
  endtask

  logic [BW-1:0] frozen;

  initial begin
    din0 = '0; din1 = '0; din_op = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    do_reset(3);

    check("rst_dout_valid", BW'(dout_valid), BW'(0));
    check("rst_dout", dout, '0);
    check("rst_flag", BW'(dout_flag), BW'(0));
    check("rst_txn_cnt", BW'(txn_cnt), BW'(0));
    check("rst_din_ready", BW'(din_ready), BW'(1));

    // Basic add, latency of two edges
    din0 = {32'd4, 32'd3, 32'd2, 32'd1};
    din1 = {32'd40, 32'd30, 32'd20, 32'd10};
    din_op = 1'b0; din_valid = 1'b1; dout_ready = 1'b1;
    cycle();
    din_valid = 1'b0;
    check("lat_not_yet", BW'(dout_valid), BW'(0));
    cycle();
    check("lat_valid", BW'(dout_valid), BW'(1));
    check("add_dout", dout, {32'd44, 32'd33, 32'd22, 32'd11});
    check("add_flag", BW'(dout_flag), BW'(0));
    cycle();
    check("add_txn_cnt", BW'(txn_cnt), BW'(1));

    // Carry and borrow boundaries
    din0 = {96'd0, 32'hFFFF_FFFF};
    din1 = {96'd0, 32'd1};
    din_op = 1'b0; din_valid = 1'b1;
    cycle();
    din0 = {64'd0, 32'd5, 32'd0};
    din1 = {64'd0, 32'd7, 32'd0};
    din_op = 1'b1;
    cycle();
`ifdef SATURATE_EN
    check("carry_dout", dout, {96'd0, 32'hFFFF_FFFF});
`else
    check("carry_dout", dout, '0);
`endif
    check("carry_flag", BW'(dout_flag), BW'(4'b0001));
    din_valid = 1'b0;
    cycle();
`ifdef SATURATE_EN
    check("borrow_dout", dout, '0);
`else
    check("borrow_dout", dout, {64'd0, 32'hFFFF_FFFE, 32'd0});
`endif
    check("borrow_flag", BW'(dout_flag), BW'(4'b0010));
    drain();

    // Backpressure: exactly two beats fit, output frozen on the first
    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din_valid = 1'b1;
      rand_data();
      cycle();
    end
    check("bp_accepted", BW'(exp_q.size()), BW'(2));
    check("bp_din_ready", BW'(din_ready), BW'(0));
    check("bp_head", dout, exp_q[0].data);
    frozen = dout;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle();
      check("bp_frozen", dout, frozen);
    end
    drain();

    // Random streaming, 100 beats
    do_reset(1);
    for (int i = 0; i < 3000 && n_pushed < 100; i++) begin
      din_valid  = 1'($urandom_range(0, 1));
      dout_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle();
    end
    check("stream_pushed", BW'(n_pushed), BW'(100));
    drain();
    check("stream_txn_cnt", BW'(txn_cnt), BW'(100));
    check("stream_cnt4", BW'(d4_cnt), BW'(4));

    // Reset while full
    dout_ready = 1'b0;
    din_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle();
    end
    check("full_din_ready", BW'(din_ready), BW'(0));
    do_reset(1);
    check("mid_rst_valid", BW'(dout_valid), BW'(0));
    check("mid_rst_txn", BW'(txn_cnt), BW'(0));
    check("mid_rst_dout", dout, '0);
    check("mid_rst_ready", BW'(din_ready), BW'(1));
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("no_stale", BW'(dout_valid), BW'(0));
    end

    // Narrow counter wrap: 17 handshakes
    dout_ready = 1'b1;
    din_valid  = 1'b1;
    for (int i = 0; i < 100 && n_pushed < 17; i++) begin
      rand_data();
      cycle();
    end
    drain();
    check("wrap_cnt4", BW'(d4_cnt), BW'(1));
    check("wrap_txn_cnt", BW'(txn_cnt), BW'(17));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_lane_adder.md
Name: pipelined_lane_adder

Overview:
Parametrised successor to simple_adder. Adds or subtracts LANES independent DWIDTH-bit operand pairs per beat, then delays the result through PIPE_STAGES registered stages. Full valid/ready backpressure on both sides.
Sits between socket_server_wrapper outputs (socket_dout/socket_dout_valid → din*) and its inputs (dout/dout_valid/dout_ready ↔ socket_din*) in multi-FPGA co-simulation benches.

Parameters:
DWIDTH, 32, bit width of each lane operand and result
LANES, 4, number of independent lanes per beat (≥1)
PIPE_STAGES, 2, register stages from input handshake to dout (≥1)
CNT_WIDTH, 32, width of the output transaction counter

Ports:
clk  input  1  sole clock; all logic on posedge
rst  input  1  synchronous, active-high reset
din0  input  LANES*DWIDTH  operand A; lane i = bits [i*DWIDTH +: DWIDTH]
din1  input  LANES*DWIDTH  operand B, same packing
din_op  input  1  0 = add (A+B), 1 = subtract (A−B); applies to all lanes of the beat
din_valid  input  1  input beat valid
din_ready  output  1  block accepts a beat this cycle
dout  output  LANES*DWIDTH  lane results, same packing
dout_flag  output  LANES  per-lane carry-out (add) or borrow (sub)
dout_valid  output  1  result beat valid
dout_ready  input  1  downstream accepts
txn_cnt  output  CNT_WIDTH  count of completed output handshakes

Behaviour:
- Input handshake when din_valid && din_ready; output handshake when dout_valid && dout_ready.
- Stage k (0..PIPE_STAGES−1) holds valid[k], data[k], flag[k]. ready[k] = !valid[k] || ready[k+1]; ready[PIPE_STAGES] = dout_ready; din_ready = ready[0]. The chain is combinational, with no bubbles.
- Stage 0 loads the arithmetic result on input handshake. Per lane, compute a (DWIDTH+1)-bit result: MSB → flag, low DWIDTH bits → data. Unsigned arithmetic; results wrap modulo 2^DWIDTH.
- Stage k+1 loads from stage k when ready[k+1]. valid[k+1] <= valid[k] in that case; otherwise it holds.
- dout/dout_flag/dout_valid come from the last stage. Latency is PIPE_STAGES cycles from the accepting edge to dout_valid with dout_ready held high. Throughput is 1 beat/cycle.
- With dout_ready low, the output holds stable. Stages fill; din_ready drops once all PIPE_STAGES stages are valid. dout/dout_flag must not change while dout_valid && !dout_ready.
- Simultaneous input and output handshake on a full pipe: both complete and occupancy is unchanged.
- txn_cnt increments by 1 per output handshake and wraps from 2^CNT_WIDTH−1 to 0.
- Reset: all valid[k] = 0, dout = 0, dout_flag = 0, dout_valid = 0, txn_cnt = 0. din_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats; no partial output is emitted.
- din_op is sampled only on input handshake. It is ignored when din_valid is low.

Optional Feature:
SATURATE_EN.
- Defined: lanes saturate. Add overflow → all-ones; subtract underflow → 0. dout_flag = 1 marks a saturated lane.
- Undefined: wrap arithmetic as above, with dout_flag = raw carry/borrow.
- Latency and handshake are identical in both builds.

Decomposition:
- Package lane_adder_pkg: typedef enum logic {OP_ADD, OP_SUB} op_e; function lane_op(a, b, op) returning {flag, result}, with saturation under SATURATE_EN.
- Sub-module: pipe_stage (one valid/ready register slice: valid, data, flag). Instantiated PIPE_STAGES times in a generate loop.

Test Plan:
- LANES=4, DWIDTH=32, op=ADD: din0 = {4,3,2,1}, din1 = {40,30,20,10}, dout_ready=1 → dout = {44,33,22,11}, flags = 0, dout_valid 2 cycles after acceptance, txn_cnt=1.
- Lane0 0xFFFFFFFF+1, lane1 5−7 with op=SUB (separate beats) → wrap build: 0x00000000 flag=1 and 0xFFFFFFFE flag=1. SATURATE_EN build: 0xFFFFFFFF flag=1 and 0x00000000 flag=1.
- Backpressure: dout_ready=0, push beats continuously → exactly 2 accepted, din_ready=0, dout frozen at beat 0. Release dout_ready → beats emerge in order with no loss or duplication.
- Streaming: 100 random beats with random din_valid/dout_ready → scoreboard matches all 100 in order, and txn_cnt=100.
- Reset mid-flight: pipe full, assert rst for 1 cycle → dout_valid=0, txn_cnt=0, and no stale beat appears afterward.
- CNT_WIDTH=4: run 17 beats → txn_cnt wraps to 1.
